// File: rtl/tom_int_arb.sv
// Interrupt pending/mask/arbitration controller with a request/ack/service
// handshake toward the CPU; fixed-priority or round-robin source selection.
//
// state | meaning
// IDLE  | no request outstanding; arbitrate when any source is eligible
// REQ   | intr high, vec frozen, waiting for int_ack or withdrawal
// SVC   | CPU servicing vec; leave once its pending bit is cleared
module tom_int_arb #(
  parameter int N_SRC = 5,
  parameter int RR    = 0,
  parameter int VW    = 3
) (
  input  logic             sys_clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] set,
  input  logic             clr_wr,
  input  logic [N_SRC-1:0] clr_data,
  input  logic             mask_wr,
  input  logic [N_SRC-1:0] mask_data,
  input  logic             int_ack,
  output logic             intr,
  output logic [VW-1:0]    vec,
  output logic [N_SRC-1:0] pending,
  output logic [N_SRC-1:0] mask
);

  typedef enum logic [1:0] {IDLE, REQ, SVC} state_t;

  state_t           state;
  logic [VW-1:0]    rr_ptr;
  logic [VW-1:0]    winner;
  logic [VW-1:0]    ptr_next;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] clr_bits;

  assign eligible = pending & mask;
  assign clr_bits = clr_wr ? clr_data : '0;
  assign ptr_next = (int'(vec) == N_SRC - 1) ? '0 : vec + 1'b1;

  // Scan from the search base upward with wrap; the first eligible index wins.
  always_comb begin
    int            base;
    int            idx;
    logic          found;
    logic [VW-1:0] idx_v;
    winner = '0;
    found  = 1'b0;
    base   = (RR != 0) ? int'(rr_ptr) : 0;
    idx    = 0;
    idx_v  = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = base + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      idx_v = VW'(idx);
      if (!found && eligible[idx_v]) begin
        winner = idx_v;
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      pending <= '0;
      mask    <= '0;
      state   <= IDLE;
      intr    <= 1'b0;
      vec     <= '0;
      rr_ptr  <= '0;
    end else begin
      pending <= ~clr_bits & (set | pending);
      if (mask_wr) mask <= mask_data;

      case (state)
        IDLE: begin
          if (|eligible) begin
            vec   <= winner;
            state <= REQ;
            intr  <= 1'b1;
          end
        end
        REQ: begin
          if (int_ack) begin
            state <= SVC;
            intr  <= 1'b0;
            if (RR != 0) rr_ptr <= ptr_next;
          end else if (!eligible[vec]) begin
            // source vanished before the CPU answered; no grant recorded
            state <= IDLE;
            intr  <= 1'b0;
          end
        end
        SVC: begin
          if (!pending[vec]) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          intr  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tom_int_arb.sv
// Bench for tom_int_arb: fixed-priority and round-robin instances share stimulus
// and are compared each cycle against a behavioural model, plus directed vectors.
module tb_tom_int_arb;

  logic       sys_clk = 1'b0;
  logic       reset;
  logic [4:0] set, clr_data, mask_data;
  logic       clr_wr, mask_wr, int_ack;

  logic       intr0, intr1;
  logic [2:0] vec0, vec1;
  logic [4:0] pend0, pend1, mask0, mask1;

  int errors = 0;
  int checks = 0;

  always #5 sys_clk = ~sys_clk;

  tom_int_arb #(.N_SRC(5), .RR(0), .VW(3)) dut_fp (
    .sys_clk(sys_clk), .reset(reset), .set(set), .clr_wr(clr_wr), .clr_data(clr_data),
    .mask_wr(mask_wr), .mask_data(mask_data), .int_ack(int_ack),
    .intr(intr0), .vec(vec0), .pending(pend0), .mask(mask0));

  tom_int_arb #(.N_SRC(5), .RR(1), .VW(3)) dut_rr (
    .sys_clk(sys_clk), .reset(reset), .set(set), .clr_wr(clr_wr), .clr_data(clr_data),
    .mask_wr(mask_wr), .mask_data(mask_data), .int_ack(int_ack),
    .intr(intr1), .vec(vec1), .pending(pend1), .mask(mask1));

  // Reference model: phase 0 = idle, 1 = requesting, 2 = servicing.
  logic [4:0] m_pend[2];
  logic [4:0] m_mask[2];
  int         m_phase[2];
  int         m_vec[2];
  int         m_ptr[2];

  function automatic int pick(input logic [4:0] e, input int start);
    for (int k = 0; k < 5; k++) begin
      int idx;
      idx = (start + k) % 5;
      if (e[idx]) return idx;
    end
    return 0;
  endfunction

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      logic [4:0] e;
      if (reset) begin
        m_pend[i] = '0; m_mask[i] = '0; m_phase[i] = 0; m_vec[i] = 0; m_ptr[i] = 0;
      end else begin
        e = m_pend[i] & m_mask[i];
        if (m_phase[i] == 0) begin
          if (e != 0) begin
            m_vec[i]   = pick(e, (i == 1) ? m_ptr[i] : 0);
            m_phase[i] = 1;
          end
        end else if (m_phase[i] == 1) begin
          if (int_ack) begin
            m_phase[i] = 2;
            if (i == 1) m_ptr[i] = (m_vec[i] + 1) % 5;
          end else if (!e[m_vec[i]]) begin
            m_phase[i] = 0;
          end
        end else begin
          if (!m_pend[i][m_vec[i]]) m_phase[i] = 0;
        end
        m_pend[i] = ~(clr_wr ? clr_data : 5'h00) & (set | m_pend[i]);
        if (mask_wr) m_mask[i] = mask_data;
      end
    end
  endtask

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("m0_intr", int'(intr0), (m_phase[0] == 1) ? 1 : 0);
    chk("m0_pend", int'(pend0), int'(m_pend[0]));
    chk("m0_mask", int'(mask0), int'(m_mask[0]));
    if (m_phase[0] != 0) chk("m0_vec", int'(vec0), m_vec[0]);
    chk("m1_intr", int'(intr1), (m_phase[1] == 1) ? 1 : 0);
    chk("m1_pend", int'(pend1), int'(m_pend[1]));
    chk("m1_mask", int'(mask1), int'(m_mask[1]));
    if (m_phase[1] != 0) chk("m1_vec", int'(vec1), m_vec[1]);
  endtask

  task automatic step();
    model_step();
    @(posedge sys_clk);
    #1;
    check_model();
  endtask

  task automatic idle_inputs();
    set = '0; clr_wr = 1'b0; clr_data = '0; mask_wr = 1'b0; mask_data = '0; int_ack = 1'b0;
  endtask

  typedef struct {
    logic [4:0] set;
    logic       clr_wr;
    logic [4:0] clr_data;
    logic       mask_wr;
    logic [4:0] mask_data;
    logic       ack;
    logic       e_intr;
    logic [2:0] e_vec;
    logic [4:0] e_pend;
    logic [4:0] e_mask;
  } row_t;

  localparam int NROW = 30;
  row_t tbl[NROW];

  initial begin
    tbl[0]  = '{5'h00, 1'b0, 5'h00, 1'b1, 5'h1F, 1'b0, 1'b0, 3'd0, 5'h00, 5'h1F};
    tbl[1]  = '{5'h04, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h04, 5'h1F};
    tbl[2]  = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b1, 3'd2, 5'h04, 5'h1F};
    tbl[3]  = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b1, 3'd2, 5'h04, 5'h1F};
    tbl[4]  = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b1, 1'b0, 3'd2, 5'h04, 5'h1F};
    tbl[5]  = '{5'h00, 1'b1, 5'h04, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h00, 5'h1F};
    tbl[6]  = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h00, 5'h1F};
    tbl[7]  = '{5'h12, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h12, 5'h1F};
    tbl[8]  = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b1, 3'd1, 5'h12, 5'h1F};
    tbl[9]  = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b1, 1'b0, 3'd1, 5'h12, 5'h1F};
    tbl[10] = '{5'h00, 1'b1, 5'h02, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h10, 5'h1F};
    tbl[11] = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h10, 5'h1F};
    tbl[12] = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b1, 3'd4, 5'h10, 5'h1F};
    tbl[13] = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b1, 1'b0, 3'd4, 5'h10, 5'h1F};
    tbl[14] = '{5'h00, 1'b1, 5'h10, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h00, 5'h1F};
    tbl[15] = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h00, 5'h1F};
    tbl[16] = '{5'h02, 1'b1, 5'h02, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h00, 5'h1F};
    tbl[17] = '{5'h09, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h09, 5'h1F};
    tbl[18] = '{5'h00, 1'b1, 5'h08, 1'b1, 5'h00, 1'b0, 1'b1, 3'd0, 5'h01, 5'h00};
    tbl[19] = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h01, 5'h00};
    tbl[20] = '{5'h00, 1'b1, 5'h01, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h00, 5'h00};
    tbl[21] = '{5'h04, 1'b0, 5'h00, 1'b1, 5'h1F, 1'b0, 1'b0, 3'd0, 5'h04, 5'h1F};
    tbl[22] = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b1, 3'd2, 5'h04, 5'h1F};
    tbl[23] = '{5'h00, 1'b0, 5'h00, 1'b1, 5'h1B, 1'b0, 1'b1, 3'd2, 5'h04, 5'h1B};
    tbl[24] = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h04, 5'h1B};
    tbl[25] = '{5'h00, 1'b0, 5'h00, 1'b1, 5'h1F, 1'b0, 1'b0, 3'd0, 5'h04, 5'h1F};
    tbl[26] = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b1, 3'd2, 5'h04, 5'h1F};
    tbl[27] = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b1, 1'b0, 3'd2, 5'h04, 5'h1F};
    tbl[28] = '{5'h03, 1'b0, 5'h00, 1'b0, 5'h00, 1'b0, 1'b0, 3'd0, 5'h07, 5'h1F};
    tbl[29] = '{5'h00, 1'b0, 5'h00, 1'b0, 5'h00, 1'b1, 1'b0, 3'd0, 5'h07, 5'h1F};

    idle_inputs();
    reset = 1'b1;
    #2;
    step();
    chk("rst_intr", int'(intr0), 0);
    chk("rst_pend", int'(pend0), 0);
    chk("rst_mask", int'(mask0), 0);
    chk("rst_vec", int'(vec0), 0);
    reset = 1'b0;

    // directed vectors on the fixed-priority instance
    for (int r = 0; r < NROW; r++) begin
      set = tbl[r].set; clr_wr = tbl[r].clr_wr; clr_data = tbl[r].clr_data;
      mask_wr = tbl[r].mask_wr; mask_data = tbl[r].mask_data; int_ack = tbl[r].ack;
      step();
      chk($sformatf("tbl%0d_intr", r), int'(intr0), int'(tbl[r].e_intr));
      chk($sformatf("tbl%0d_pend", r), int'(pend0), int'(tbl[r].e_pend));
      chk($sformatf("tbl%0d_mask", r), int'(mask0), int'(tbl[r].e_mask));
      if (tbl[r].e_intr) chk($sformatf("tbl%0d_vec", r), int'(vec0), int'(tbl[r].e_vec));
    end
    idle_inputs();

    // reset while servicing vec=2 with pending=0x07
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("svc_rst_intr", int'(intr0), 0);
    chk("svc_rst_vec", int'(vec0), 0);
    chk("svc_rst_pend", int'(pend0), 0);
    chk("svc_rst_mask", int'(mask0), 0);
    int_ack = 1'b1;
    step();
    int_ack = 1'b0;
    chk("idle_ack_intr", int'(intr0), 0);
    chk("idle_ack_pend", int'(pend0), 0);

    // round-robin: sources 0 and 3 held set, each granted, acked, cleared
    mask_wr = 1'b1; mask_data = 5'h1F; set = 5'h09;
    step();
    mask_wr = 1'b0;
    for (int g = 0; g < 4; g++) begin
      int n;
      n = 0;
      while (!intr1 && n < 10) begin
        step();
        n++;
      end
      chk($sformatf("rr_grant%0d_seen", g), int'(intr1), 1);
      chk($sformatf("rr_grant%0d_vec", g), int'(vec1), (g % 2 == 0) ? 0 : 3);
      int_ack = 1'b1;
      step();
      int_ack = 1'b0;
      chk($sformatf("rr_ack%0d_intr", g), int'(intr1), 0);
      clr_wr = 1'b1; clr_data = 5'(1 << vec1);
      step();
      clr_wr = 1'b0;
    end
    idle_inputs();

    // randomized traffic against the model
    for (int c = 0; c < 4000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      set       = 5'($urandom) & 5'($urandom) & 5'($urandom);
      clr_wr    = ($urandom_range(0, 3) == 0);
      clr_data  = 5'($urandom);
      mask_wr   = ($urandom_range(0, 7) == 0);
      mask_data = 5'($urandom) | 5'($urandom);
      int_ack   = ($urandom_range(0, 2) == 0);
      step();
    end
    idle_inputs();
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
